// File: rtl/pueo_cmd_pkg.sv
// Shared types for the PUEO command dispatcher: command word layout, type nibbles,
// FIFO entry and packet state.
package pueo_cmd_pkg;

  localparam logic [3:0] TYPE_BIT       = 4'b0000;
  localparam logic [3:0] TYPE_BYTE      = 4'b0001;
  localparam logic [3:0] TYPE_BYTE_LAST = 4'b0101;
  localparam logic [3:0] ADDR_BCAST     = 4'hF;

  typedef struct packed {
    logic [3:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  payload;
    logic        trig;
    logic [14:0] trig_time;
  } cmd_word_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_ent_t;

  typedef enum logic {PASS = 1'b0, DISCARD = 1'b1} pkt_state_t;

endpackage

// File: rtl/pueo_cmd_if.sv
// AXI4-Stream byte channel from the dispatcher to the command processor.
interface pueo_cmd_if;
  logic [7:0] cmdproc_tdata;
  logic       cmdproc_tvalid;
  logic       cmdproc_tlast;
  logic       cmdproc_tready;

  modport master (output cmdproc_tdata, cmdproc_tvalid, cmdproc_tlast, input cmdproc_tready);
  modport slave  (input cmdproc_tdata, cmdproc_tvalid, cmdproc_tlast, output cmdproc_tready);
endinterface

// File: rtl/pueo_cmd_fifo.sv
// First-word-fall-through FIFO; full is relaxed by a same-cycle pop, flush wins over push.
module pueo_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pueo_cmd_dispatch.sv
// Command-word dispatcher: bit commands, triggers and packetised command-processor bytes.
// Optional statistics counters are built when PUEO_CMD_STATS_EN is defined.
module pueo_cmd_dispatch
  import pueo_cmd_pkg::*;
#(
  parameter logic [3:0] CMDPROC_ADDR = 4'h0,
  parameter int         FIFO_DEPTH   = 16
) (
  input  logic              sysclk_i,
  input  logic              sysrst_n_i,
  input  logic [31:0]       command_i,
  input  logic              command_valid_i,
  output logic              cmdsync_o,
  output logic              cmdpps_o,
  output logic              cmdproc_rst_o,
  pueo_cmd_if.master        cmdproc,
  output logic [14:0]       trig_time_o,
  output logic              trig_valid_o,
  output logic              overflow_o,
  output logic [15:0]       trig_count_o,
  output logic [15:0]       drop_count_o
);

  cmd_word_t  cmd_q;
  logic       vld_q;
  pkt_state_t state_q, state_d;
  logic       is_bit, addr_hit, byte_sel, byte_last;
  logic       pop, push, drop, fifo_full, fifo_empty, eff_full;
  fifo_ent_t  wr_ent, rd_ent;

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      cmd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      cmd_q <= command_i;
      vld_q <= command_valid_i;
    end
  end

  assign is_bit        = vld_q && (cmd_q.typ == TYPE_BIT);
  assign cmdsync_o     = is_bit && cmd_q.payload[0];
  assign cmdpps_o      = is_bit && cmd_q.payload[1];
  assign cmdproc_rst_o = is_bit && cmd_q.payload[2];
  assign trig_valid_o  = vld_q && cmd_q.trig;
  assign trig_time_o   = cmd_q.trig_time;

  assign addr_hit  = (cmd_q.addr == CMDPROC_ADDR) || (cmd_q.addr == ADDR_BCAST);
  assign byte_sel  = vld_q && addr_hit &&
                     ((cmd_q.typ == TYPE_BYTE) || (cmd_q.typ == TYPE_BYTE_LAST));
  // Bit 30 of the word is the only difference between the two byte types.
  assign byte_last = cmd_q.typ[2];

  assign pop      = cmdproc.cmdproc_tvalid && cmdproc.cmdproc_tready;
  assign eff_full = fifo_full && !pop;

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) state_q <= PASS;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    drop    = 1'b0;
    if (cmdproc_rst_o) begin
      state_d = PASS;
    end else if (byte_sel) begin
      unique case (state_q)
        PASS: begin
          if (!eff_full) begin
            push = 1'b1;
          end else begin
            drop = 1'b1;
            if (!byte_last) state_d = DISCARD;
          end
        end
        DISCARD: begin
          drop = 1'b1;
          if (byte_last) state_d = PASS;
        end
        default: state_d = PASS;
      endcase
    end
  end

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i)        overflow_o <= 1'b0;
    else if (cmdproc_rst_o) overflow_o <= 1'b0;
    else if (drop)          overflow_o <= 1'b1;
  end

  assign wr_ent = '{last: byte_last, data: cmd_q.payload};

  pueo_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk   (sysclk_i),
    .rst_n (sysrst_n_i),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .flush (cmdproc_rst_o),
    .rdata (rd_ent),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Data is masked while empty so the idle bus reads as zero.
  assign cmdproc.cmdproc_tvalid = !fifo_empty;
  assign cmdproc.cmdproc_tdata  = fifo_empty ? 8'h00 : rd_ent.data;
  assign cmdproc.cmdproc_tlast  = !fifo_empty && rd_ent.last;

`ifdef PUEO_CMD_STATS_EN
  logic [15:0] trig_cnt_q, drop_cnt_q;

  always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
    if (!sysrst_n_i) begin
      trig_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (cmdproc_rst_o) begin
      trig_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (trig_valid_o && (trig_cnt_q != 16'hFFFF)) trig_cnt_q <= trig_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != 16'hFFFF))         drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign trig_count_o = trig_cnt_q;
  assign drop_count_o = drop_cnt_q;
`else
  assign trig_count_o = 16'h0000;
  assign drop_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pueo_cmd_dispatch.sv
// Bench for pueo_cmd_dispatch: decode table, directed packet/overflow/reset sequences
// and a randomized run against a queue-based model.
module tb_pueo_cmd_dispatch;
  localparam int         DEPTH = 16;
  localparam logic [3:0] ADDR  = 4'h0;

  logic        sysclk_i = 1'b0;
  logic        sysrst_n_i;
  logic [31:0] command_i;
  logic        command_valid_i;
  logic        cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o, overflow_o;
  logic [14:0] trig_time_o;
  logic [15:0] trig_count_o, drop_count_o;

  pueo_cmd_if cmdproc_bus();

  pueo_cmd_dispatch #(.CMDPROC_ADDR(ADDR), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk_i        (sysclk_i),
    .sysrst_n_i      (sysrst_n_i),
    .command_i       (command_i),
    .command_valid_i (command_valid_i),
    .cmdsync_o       (cmdsync_o),
    .cmdpps_o        (cmdpps_o),
    .cmdproc_rst_o   (cmdproc_rst_o),
    .cmdproc         (cmdproc_bus),
    .trig_time_o     (trig_time_o),
    .trig_valid_o    (trig_valid_o),
    .overflow_o      (overflow_o),
    .trig_count_o    (trig_count_o),
    .drop_count_o    (drop_count_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Apply one word for one clock; returns #1 after the edge that captured it.
  task automatic step(input logic v, input logic [31:0] c, input logic rdy);
    command_valid_i = v;
    command_i       = c;
    cmdproc_bus.cmdproc_tready = rdy;
    @(posedge sysclk_i);
    #1;
  endtask

  function automatic logic [31:0] bw(input logic [3:0] t, input logic [3:0] a, input logic [7:0] d);
    return {t, a, d, 16'h0000};
  endfunction

  typedef struct {
    logic        v;
    logic [31:0] cmd;
    logic [3:0]  exp_bits;   // {sync, pps, rst, trig}
    logic [14:0] exp_time;
  } vec_t;

  vec_t tbl[8];

  // model state for the randomized phase
  logic [8:0]  mq[$];
  logic        mdisc, movf;
  logic [15:0] mtc, mdc;

  initial begin
    logic [31:0] pw, w;
    logic        pv, rdy, ebit, sel, lst;
    int          got;
    logic [8:0]  lastb;

    tbl[0] = '{1'b1, 32'h0001_0000, 4'b1000, 15'h0};
    tbl[1] = '{1'b1, 32'h0002_0000, 4'b0100, 15'h0};
    tbl[2] = '{1'b1, 32'h0007_0000, 4'b1110, 15'h0};
    tbl[3] = '{1'b1, 32'h0000_8123, 4'b0001, 15'h0123};
    tbl[4] = '{1'b1, 32'h0000_0123, 4'b0000, 15'h0};
    tbl[5] = '{1'b1, 32'h2007_8000, 4'b0001, 15'h0000};
    tbl[6] = '{1'b1, 32'h1001_FFFF, 4'b0001, 15'h7FFF};
    tbl[7] = '{1'b0, 32'h0007_8000, 4'b0000, 15'h0};

    sysrst_n_i = 1'b0;
    command_i = '0;
    command_valid_i = 1'b0;
    cmdproc_bus.cmdproc_tready = 1'b0;
    repeat (3) @(posedge sysclk_i);
    #1;
    chk("reset_outs", {cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o, overflow_o,
                       cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast}, 0);
    chk("reset_tdata", cmdproc_bus.cmdproc_tdata, 0);
    chk("reset_counts", {trig_count_o, drop_count_o}, 0);
    sysrst_n_i = 1'b1;
    step(0, 0, 1);

    // decode table: pulse at T+1, gone at T+2
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].cmd, 1);
      chk($sformatf("tbl%0d_bits", i), {cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o}, tbl[i].exp_bits);
      if (tbl[i].exp_bits[0]) chk($sformatf("tbl%0d_time", i), trig_time_o, tbl[i].exp_time);
      step(0, 0, 1);
      chk($sformatf("tbl%0d_gone", i), {cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o}, 0);
    end
    step(1, 32'h0004_0000, 1);
    step(0, 0, 1);
    step(0, 0, 1);

    // two-byte packet, first tvalid at T+2
    step(1, bw(4'h1, ADDR, 8'hAB), 1);
    chk("pkt_t1_tvalid", cmdproc_bus.cmdproc_tvalid, 0);
    step(1, bw(4'h5, ADDR, 8'hCD), 1);
    chk("pkt_b0", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b10, 8'hAB});
    step(0, 0, 1);
    chk("pkt_b1", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b11, 8'hCD});
    step(0, 0, 1);
    chk("pkt_idle", cmdproc_bus.cmdproc_tvalid, 0);

    // foreign address ignored, broadcast accepted
    step(1, bw(4'h1, 4'h3, 8'hAB), 1);
    step(1, bw(4'h5, 4'h3, 8'hCD), 1);
    chk("foreign_a", cmdproc_bus.cmdproc_tvalid, 0);
    step(0, 0, 1);
    chk("foreign_b", cmdproc_bus.cmdproc_tvalid, 0);
    step(1, bw(4'h1, 4'hF, 8'hAB), 1);
    step(1, bw(4'h5, 4'hF, 8'hCD), 1);
    chk("bcast_b0", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b10, 8'hAB});
    step(0, 0, 1);
    chk("bcast_b1", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b11, 8'hCD});
    step(0, 0, 1);

    // overflow: 17 bytes + last into a stalled FIFO
    for (int i = 0; i < 17; i++) step(1, bw(4'h1, ADDR, 8'(i)), 0);
    step(1, bw(4'h5, ADDR, 8'hEE), 0);
    step(0, 0, 0);
    chk("ovf_flag", overflow_o, 1);
`ifdef PUEO_CMD_STATS_EN
    chk("ovf_drop_count", drop_count_o, 2);
`endif
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovf_keep%0d", k),
          {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b10, 8'(k)});
      step(0, 0, 1);
    end
    chk("ovf_drained", cmdproc_bus.cmdproc_tvalid, 0);
    step(1, bw(4'h1, ADDR, 8'h11), 1);
    step(1, bw(4'h5, ADDR, 8'h22), 1);
    chk("ovf_next_b0", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b10, 8'h11});
    step(0, 0, 1);
    chk("ovf_next_b1", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b11, 8'h22});
    chk("ovf_sticky", overflow_o, 1);
    step(0, 0, 1);

    // command-processor reset mid-packet
    step(1, bw(4'h1, ADDR, 8'h31), 0);
    step(1, bw(4'h1, ADDR, 8'h32), 0);
    step(1, 32'h0004_0000, 0);
    chk("crst_pulse", {cmdproc_rst_o, cmdproc_bus.cmdproc_tvalid}, 2'b11);
    step(0, 0, 0);
    chk("crst_after", {cmdproc_rst_o, cmdproc_bus.cmdproc_tvalid, overflow_o}, 0);
`ifdef PUEO_CMD_STATS_EN
    chk("crst_drop_count", drop_count_o, 0);
`endif

    // full FIFO, push coinciding with a pop
    for (int i = 0; i < 16; i++) step(1, bw(4'h1, ADDR, 8'(8'h40 + i)), 0);
    step(1, bw(4'h5, ADDR, 8'h99), 0);
    step(0, 0, 1);
    cmdproc_bus.cmdproc_tready = 1'b0;
    #1;
    chk("fullpop_ovf", overflow_o, 0);
    got = 0;
    lastb = '0;
    for (int k = 0; k < 24; k++) begin
      if (cmdproc_bus.cmdproc_tvalid) begin
        got++;
        lastb = {cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata};
      end
      step(0, 0, 1);
    end
    chk("fullpop_count", got, 16);
    chk("fullpop_last", lastb, {1'b1, 8'h99});

    // randomized run against the queue model
    step(1, 32'h0004_0000, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    mq.delete();
    mdisc = 0; movf = 0; mtc = 0; mdc = 0;
    pv = 0; pw = 0;
    for (int i = 0; i < 1500; i++) begin
      rdy = ((i / 100) % 2 == 1) ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      cmdproc_bus.cmdproc_tready = rdy;
      ebit = pv && (pw[31:28] == 4'h0);
      chk("rnd_bits", {cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o},
          {ebit && pw[16], ebit && pw[17], ebit && pw[18], pv && pw[15]});
      if (pv && pw[15]) chk("rnd_time", trig_time_o, pw[14:0]);
      chk("rnd_tvalid", cmdproc_bus.cmdproc_tvalid, mq.size() != 0);
      if (mq.size() != 0)
        chk("rnd_data", {cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, mq[0]);
      chk("rnd_ovf", overflow_o, movf);
`ifdef PUEO_CMD_STATS_EN
      chk("rnd_counts", {trig_count_o, drop_count_o}, {mtc, mdc});
`endif
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (ebit && pw[18]) begin
        mq.delete();
        mdisc = 0; movf = 0; mtc = 0; mdc = 0;
      end else begin
        if (pv && pw[15] && mtc != 16'hFFFF) mtc++;
        sel = pv && (pw[31:28] == 4'h1 || pw[31:28] == 4'h5) &&
              (pw[27:24] == ADDR || pw[27:24] == 4'hF);
        if (sel) begin
          lst = pw[30];
          if (mdisc || mq.size() >= DEPTH) begin
            movf = 1;
            if (mdc != 16'hFFFF) mdc++;
            if (mdisc) mdisc = !lst;
            else       mdisc = !lst;
          end else begin
            mq.push_back({lst, pw[23:16]});
          end
        end
      end
      w = $urandom;
      case ($urandom % 16)
        0, 1, 2:                 begin w[31:28] = 4'h0; w[18] = ($urandom % 40 == 0); end
        3, 4, 5, 6, 7, 8, 9:     w[31:28] = 4'h1;
        10, 11, 12, 13:          w[31:28] = 4'h5;
        default:                 w[31:28] = 4'($urandom_range(6, 15));
      endcase
      case ($urandom % 4)
        0: w[27:24] = ADDR;
        1: w[27:24] = 4'hF;
        2: w[27:24] = 4'h3;
        default: ;
      endcase
      pv = ($urandom % 8 != 0);
      pw = w;
      command_i = pw;
      command_valid_i = pv;
      @(posedge sysclk_i);
      #1;
    end

    // asynchronous reset mid-stream
    step(0, 0, 1);
    repeat (20) step(0, 0, 1);
    step(1, bw(4'h1, ADDR, 8'h77), 0);
    step(1, 32'h0001_8005, 0);
    chk("arst_pre", {cmdsync_o, trig_valid_o, cmdproc_bus.cmdproc_tvalid}, 3'b111);
    #1 sysrst_n_i = 1'b0;
    #1;
    chk("arst_outs", {cmdsync_o, cmdpps_o, cmdproc_rst_o, trig_valid_o, overflow_o,
                      cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast}, 0);
    chk("arst_data", {cmdproc_bus.cmdproc_tdata, trig_time_o}, 0);
    @(posedge sysclk_i);
    #1 sysrst_n_i = 1'b1;
    step(1, bw(4'h5, ADDR, 8'h5A), 1);
    step(0, 0, 1);
    chk("arst_resume", {cmdproc_bus.cmdproc_tvalid, cmdproc_bus.cmdproc_tlast, cmdproc_bus.cmdproc_tdata}, {2'b11, 8'h5A});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pueo_cmd_dispatch.md
# pueo_cmd_dispatch

Registered, parametrised command-word dispatcher for the 32-bit downstream command stream. It decodes each valid command word into trigger, bit-command and command-processor traffic. Command-processor bytes are buffered in a FIFO that honours `cmdproc_tready`, and packet-level overflow handling discards whole packets. It sits between the command-link deserialiser and the command processor, and adds a configurable address, a full AXI4-Stream handshake and error reporting.

## Interface
Parameters:
- `CMDPROC_ADDR`, 4'h0, this board's 4-bit command address; 4'hF is always accepted as broadcast.
- `FIFO_DEPTH`, 16, command-processor byte FIFO depth; must be a power of 2, minimum 4.

Ports:
- `sysclk_i` in 1: system clock; all logic is in this domain.
- `sysrst_n_i` in 1: asynchronous, active-low reset.
- `command_i` in 32: command word.
- `command_valid_i` in 1: `command_i` is valid this cycle.
- `cmdsync_o` out 1: SYNC bit-command pulse.
- `cmdpps_o` out 1: PPS bit-command pulse.
- `cmdproc_rst_o` out 1: command-processor reset pulse.
- `cmdproc_tdata` out 8: AXI4-Stream byte to the command processor.
- `cmdproc_tvalid` out 1: stream valid.
- `cmdproc_tlast` out 1: last byte of a packet.
- `cmdproc_tready` in 1: stream ready.
- `trig_time_o` out 15: trigger time, taken from `command_i[14:0]`.
- `trig_valid_o` out 1: trigger pulse.
- `overflow_o` out 1: sticky flag, set on any dropped byte.
- `trig_count_o` out 16: trigger counter (statistics build only).
- `drop_count_o` out 16: dropped-byte counter (statistics build only).

## Operation
- Stage 0 registers `command_i` and `command_valid_i`. All decoding works on the registered word.
- Type field `[31:28]`:
  - 4'b0000: bit command. Bit 16 produces `cmdsync_o`, bit 17 `cmdpps_o`, bit 18 `cmdproc_rst_o`. Each is a one-cycle pulse, and several can be set in one word.
  - 4'b0001: command-processor byte, not last.
  - 4'b0101: command-processor byte, last. Bit 30 is stored as the byte's last flag.
  - All other values: ignored for byte and bit purposes.
- A byte is selected only if `[27:24]` equals `CMDPROC_ADDR` or 4'hF.
- Trigger decoding is independent of the type field: `[15]` set on a valid word produces a `trig_valid_o` pulse with `trig_time_o` = `[14:0]`. A trigger and a byte in the same word are both processed.
- Each selected byte goes through the packet state machine, whose states are PASS and DISCARD. Reset state is PASS.
  - PASS, FIFO not full: push {last, data}.
  - PASS, FIFO full: drop the byte, set `overflow_o`, increment the drop count. If the byte is not last, go to DISCARD.
  - DISCARD: drop every byte and count each one. A last byte returns the machine to PASS; that last byte is itself dropped.
- FIFO "full" is evaluated after a same-cycle pop: a push into a full FIFO while `tvalid & tready` is accepted.
- `cmdproc_rst_o` flushes the FIFO, returns the state machine to PASS and clears `overflow_o`, all in the same cycle as the pulse. Any byte push in that cycle is lost without being counted.
- The output side holds `cmdproc_tdata` and `cmdproc_tlast` stable while `tvalid & !tready`.

## Timing
- Reset values: every output is 0, the FIFO is empty, the state is PASS, and the counters are 0.
- Bit-command and trigger pulses appear exactly 1 cycle after the input word.
- Byte path: `cmdproc_tvalid` rises 2 cycles after the input word when the FIFO was empty. The FIFO is first-word fall-through.
- Sustained throughput is 1 byte per cycle in and out.
- Asserting reset mid-packet drops everything asynchronously; after release the block resumes in PASS.

## Configuration
- `PUEO_CMD_STATS_EN`:
  - Defined: `trig_count_o` counts `trig_valid_o` pulses and `drop_count_o` counts dropped bytes. Both are 16-bit and saturate at 16'hFFFF. Both are cleared by reset and by `cmdproc_rst_o`.
  - Undefined: both outputs are tied to 0 and no counter logic is built.
  - `overflow_o` is present in both builds.

## Structure
- Package `pueo_cmd_pkg` holds:
  - type-nibble constants: BIT 4'b0000, BYTE 4'b0001, BYTE_LAST 4'b0101;
  - the broadcast address 4'hF;
  - a packed struct for the command word: type, addr, payload byte, trig flag, trig time;
  - the enum for PASS/DISCARD.
- Sub-module `pueo_cmd_fifo`: a synchronous FWFT FIFO, 9 bits wide and `FIFO_DEPTH` deep, with push, pop, flush, full and empty.

## Test plan
- `0x0001_0000` → `cmdsync_o` high for exactly 1 cycle at T+1. `0x0007_0000` → all three bit pulses at T+1.
- `0x0000_8123` → `trig_valid_o` pulse at T+1 with `trig_time_o` = 15'h0123. `0x0000_0123` → no pulse.
- `0x10AB_0000` then `0x50CD_0000`, tready=1 → stream 0xAB (tlast=0) then 0xCD (tlast=1), first tvalid at T+2. Same words with address 4'h3 and `CMDPROC_ADDR`=0 → nothing emitted. Address 4'hF → emitted.
- tready=0 with 17 non-last bytes then one last byte (DEPTH 16) → the 16 stored bytes are preserved; byte 17 and the last byte are dropped; `overflow_o`=1; drop_count=2 with stats enabled. The next packet passes normally.
- FIFO full, then a push in the same cycle as a pop → the byte is accepted, `overflow_o` stays 0.
- Mid-packet `0x0004_0000` → `cmdproc_rst_o` pulse, FIFO empty, `overflow_o` cleared. Assert `sysrst_n_i` mid-stream → all outputs 0 immediately.
